// File: rtl/i2s_capture_pkg.sv
// i2s_capture_pkg: register map, bit positions and sequencer states for i2s_capture.
package i2s_capture_pkg;
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_DIV    = 2'd3;
    localparam int CTRL_EN    = 0;
    localparam int CTRL_FLUSH = 1;
    localparam int CTRL_TH    = 8;
    localparam int ST_EMPTY   = 16;
    localparam int ST_FULL    = 17;
    localparam int ST_OVF     = 18;
    localparam int ENT_RIGHT  = 31;
    localparam int ENT_CH     = 28;
    typedef enum logic {SEQ_IDLE = 1'b0, SEQ_PUSH = 1'b1} seq_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; a push while full succeeds only alongside a pop.
module sync_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 64
) (
    input  logic                   ck,
    input  logic                   resetn,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DW-1:0]          din,
    output logic [DW-1:0]          dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;
    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign level   = cnt_q;
    assign dout    = mem_q[rp_q];
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    always_ff @(posedge ck or negedge resetn) begin
        if (!resetn) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else if (clr) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + 1'b1;
            if (do_pop) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge ck) begin
        if (do_push && !clr) mem_q[wp_q] <= din;
    end
endmodule

// File: rtl/i2s_capture.sv
// i2s_capture: I2S master receiver with tagged sample FIFO on the PicoSoC iomem bus.
module i2s_capture
    import i2s_capture_pkg::*;
#(
    parameter logic [15:0] ADDR      = 16'h6000,
    parameter int          CHANNELS  = 4,
    parameter int          WIDTH     = 16,
    parameter int          DEPTH     = 64,
    parameter logic [7:0]  DIV_RESET = 8'd7
) (
    input  logic                ck,
    input  logic                resetn,
    input  logic                iomem_valid,
    output logic                iomem_ready,
    input  logic [3:0]          iomem_wstrb,
    input  logic [31:0]         iomem_addr,
    input  logic [31:0]         iomem_wdata,
    output logic [31:0]         iomem_rdata,
    output logic                i2s_sck,
    output logic                i2s_ws,
    input  logic [CHANNELS-1:0] i2s_d,
    output logic                irq
);
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int LW = $clog2(DEPTH) + 1;
    logic                             ready_q, en_q, ovf_q, ovf_d, sck_q, right_q;
    logic [7:0]                       thresh_q, div_q, cnt_q, divc;
    logic [5:0]                       b_q;
    logic [2:0]                       ch_q;
    logic [CHANNELS-1:0]              d_q;
    logic [CHANNELS-1:0][WIDTH-1:0]   sr_q, sr_d, hold_q;
    seq_e                             seq_q;
    logic                             sel, wr, flush, pop, push, ovf_clr, tick, cap, start;
    logic                             full, empty;
    logic [LW-1:0]                    level;
    logic [1:0]                       ra;
    logic [WIDTH-1:0]                 sample;
    logic [31:0]                      entry, status, dout;
    logic                             unused_ok;
    assign unused_ok = &{1'b0, iomem_addr[15:4], iomem_addr[1:0], iomem_wdata[31:19],
                         iomem_wdata[17:16], iomem_wstrb[3]};
    assign ra      = iomem_addr[3:2];
    assign sel     = iomem_valid && iomem_addr[31:16] == ADDR && !ready_q;
    assign wr      = ready_q && |iomem_wstrb;
    assign flush   = wr && ra == REG_CTRL && iomem_wstrb[0] && iomem_wdata[CTRL_FLUSH];
    assign ovf_clr = wr && ra == REG_STATUS && iomem_wstrb[2] && iomem_wdata[ST_OVF];
    assign pop     = ready_q && !(|iomem_wstrb) && ra == REG_DATA && !empty;
    assign push    = seq_q == SEQ_PUSH && !flush;
    assign divc    = div_q == 8'd0 ? 8'd1 : div_q;
    assign tick    = en_q && cnt_q == divc;
    assign cap     = tick && !sck_q && b_q[4:0] != 5'd0 && b_q[4:0] <= 5'(WIDTH);
    assign start   = tick && !sck_q && b_q[4:0] == 5'(WIDTH);
    assign i2s_sck = sck_q;
    assign i2s_ws  = b_q[5];
    assign iomem_ready = ready_q;
    assign sample  = hold_q[ch_q[CW-1:0]];
    assign irq     = ovf_q || (thresh_q != 8'd0 && 9'(level) >= 9'(thresh_q));
    // a full FIFO only overflows when no pop frees a slot in the same cycle
    assign ovf_d   = flush ? 1'b0 : (push && full && !pop) ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) sr_d[i] = {sr_q[i][WIDTH-2:0], d_q[i]};
        entry = {{(32-WIDTH){sample[WIDTH-1]}}, sample};
        entry[ENT_RIGHT] = right_q;
        entry[ENT_CH +: 3] = ch_q;
        status = '0;
        status[8:0] = 9'(level);
        status[ST_EMPTY] = empty;
        status[ST_FULL] = full;
        status[ST_OVF] = ovf_q;
        iomem_rdata = !ready_q ? 32'd0 :
                      ra == REG_CTRL   ? {16'd0, thresh_q, 7'd0, en_q} :
                      ra == REG_STATUS ? status :
                      ra == REG_DATA   ? (empty ? 32'd0 : dout) : {24'd0, div_q};
    end
    always_ff @(posedge ck or negedge resetn) begin
        if (!resetn) begin
            ready_q  <= 1'b0;
            en_q     <= 1'b0;
            thresh_q <= 8'd0;
            div_q    <= DIV_RESET;
            ovf_q    <= 1'b0;
            d_q      <= '0;
        end else begin
            ready_q <= sel;
            ovf_q   <= ovf_d;
            d_q     <= i2s_d;
            if (wr && ra == REG_CTRL && iomem_wstrb[0]) en_q <= iomem_wdata[CTRL_EN];
            if (wr && ra == REG_CTRL && iomem_wstrb[1]) thresh_q <= iomem_wdata[CTRL_TH +: 8];
            if (wr && ra == REG_DIV && iomem_wstrb[0]) div_q <= iomem_wdata[7:0];
        end
    end
    always_ff @(posedge ck or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= 8'd0;
            sck_q <= 1'b0;
            b_q   <= 6'd0;
            sr_q  <= '0;
        end else if (!en_q) begin
            cnt_q <= 8'd0;
            sck_q <= 1'b0;
            b_q   <= 6'd0;
            sr_q  <= '0;
        end else if (tick) begin
            cnt_q <= 8'd0;
            sck_q <= !sck_q;
            if (sck_q) b_q <= b_q + 6'd1;
            if (cap) sr_q <= sr_d;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end
    // samples are snapshotted so a disable mid-PUSH cannot corrupt the entries
    always_ff @(posedge ck or negedge resetn) begin
        if (!resetn) begin
            seq_q   <= SEQ_IDLE;
            ch_q    <= 3'd0;
            right_q <= 1'b0;
            hold_q  <= '0;
        end else if (start) begin
            seq_q   <= SEQ_PUSH;
            ch_q    <= 3'd0;
            right_q <= b_q[5];
            hold_q  <= sr_d;
        end else if (seq_q == SEQ_PUSH) begin
            ch_q <= ch_q + 3'd1;
            if (ch_q == 3'(CHANNELS-1)) seq_q <= SEQ_IDLE;
        end
    end
    sync_fifo #(.DW(32), .DEPTH(DEPTH)) u_fifo (
        .ck    (ck),
        .resetn(resetn),
        .clr   (flush),
        .push  (push),
        .pop   (pop),
        .din   (entry),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .level (level)
    );
endmodule

// File: tb/tb_i2s_capture.sv
// tb_i2s_capture: drives I2S frames from a slave model and checks register reads against a FIFO model.
module tb_i2s_capture;
    localparam int CH = 4, W = 16, DEPTH = 16;
    logic          ck = 0, resetn = 0, iomem_valid = 0;
    logic [3:0]    iomem_wstrb = 0;
    logic [31:0]   iomem_addr = 0, iomem_wdata = 0;
    logic [CH-1:0] i2s_d = 0;
    logic          iomem_ready, i2s_sck, i2s_ws, irq;
    logic [31:0]   iomem_rdata;

    always #5 ck = ~ck;

    i2s_capture #(.CHANNELS(CH), .WIDTH(W), .DEPTH(DEPTH)) dut (
        .ck(ck), .resetn(resetn), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata), .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .i2s_d(i2s_d), .irq(irq)
    );

    int n_err = 0, n_chk = 0, lat = 0;
    int k = 0, tot = 0, th_m = 0;
    bit drv_en = 0, rnd = 0, ovf_m = 0;
    logic [W-1:0] smp [2][CH];
    logic [31:0]  q_m [$];

    typedef struct {logic [3:0] off; logic [3:0] strb; logic [31:0] wd; logic [31:0] exp;} vec_t;
    vec_t vecs [11];

    function automatic logic [31:0] ent(int r, int c, logic [W-1:0] s);
        int v = int'(s);
        if (v >= 2**(W-1)) v -= 2**W;
        return (32'(r) << 31) | (32'(c) << 28) | (32'(v) & 32'h0FFF_FFFF);
    endfunction

    function automatic logic [31:0] status_m();
        int n = q_m.size();
        return (32'(ovf_m) << 18) | (32'(n == DEPTH) << 17) | (32'(n == 0) << 16) | 32'(n);
    endfunction

    function automatic logic irq_m();
        return ovf_m || (th_m != 0 && q_m.size() >= th_m);
    endfunction

    task automatic gen();
        for (int h = 0; h < 2; h++) for (int c = 0; c < CH; c++) smp[h][c] = W'($urandom);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // I2S slave: new bit after every SCK falling edge, MSB in slot 1
    initial begin
        forever begin
            @(negedge i2s_sck);
            if (drv_en) begin
                k = (k + 1) % 64;
                tot++;
                if (k == 0 && rnd) gen();
                for (int c = 0; c < CH; c++)
                    i2s_d[c] = (k % 32 >= 1 && k % 32 <= W) ? smp[k/32][c][W - k % 32] : 1'b0;
                if (k % 32 == W + 1)
                    for (int c = 0; c < CH; c++) begin
                        if (q_m.size() < DEPTH) q_m.push_back(ent(k/32, c, smp[k/32][c]));
                        else ovf_m = 1;
                    end
            end
        end
    end

    task automatic bus(input logic [3:0] off, input logic [3:0] strb, input logic [31:0] wd,
                       output logic [31:0] rd);
        bit got = 0;
        rd = 0;
        @(negedge ck);
        iomem_valid = 1;
        iomem_addr = 32'h6000_0000 | 32'(off);
        iomem_wstrb = strb;
        iomem_wdata = wd;
        for (int n = 0; n < 20 && !got; n++) begin
            @(posedge ck);
            #1;
            if (iomem_ready) begin
                got = 1;
                rd = iomem_rdata;
                lat = n;
            end
        end
        if (!got) begin
            n_chk++;
            n_err++;
            $display("FAIL bus_timeout: no ready for offset %h", off);
        end
        @(posedge ck);
        #1;
        iomem_valid = 0;
        iomem_wstrb = 0;
    endtask

    task automatic wr(input logic [3:0] off, input logic [3:0] strb, input logic [31:0] d);
        logic [31:0] x;
        bus(off, strb, d, x);
    endtask

    task automatic rdchk(input string nm, input logic [3:0] off, input logic [31:0] exp);
        logic [31:0] x;
        bus(off, 4'h0, 32'h0, x);
        chk(nm, x, exp);
    endtask

    task automatic popchk(input string nm, output logic [31:0] x);
        logic [31:0] e;
        bus(4'h8, 4'h0, 32'h0, x);
        e = q_m.size() != 0 ? q_m.pop_front() : 32'h0;
        chk(nm, x, e);
    endtask

    task automatic ctrl(input logic [31:0] v);
        wr(4'h0, 4'b0011, v);
        th_m = int'(v[15:8]);
        if (v[1]) begin
            q_m.delete();
            ovf_m = 0;
        end
    endtask

    task automatic start(input logic [31:0] v, input bit r);
        rnd = r;
        k = 0;
        tot = 0;
        if (r) gen();
        i2s_d = '0;
        drv_en = 1;
        ctrl(v);
    endtask

    task automatic stop(input logic [31:0] v);
        drv_en = 0;
        ctrl(v);
        repeat (4) @(posedge ck);
        #1;
    endtask

    task automatic wait_tot(input int t);
        bit ok = 0;
        for (int n = 0; n < 5000 && !ok; n++) begin
            @(posedge ck);
            #1;
            ok = tot >= t;
        end
        if (!ok) begin
            n_chk++;
            n_err++;
            $display("FAIL wait_edges: reached %0d of %0d SCK edges", tot, t);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] x;
        int t0, t1;
        logic p;
        vecs = '{
            '{4'h0, 4'b0000, 32'h0,         32'h0},
            '{4'h4, 4'b0000, 32'h0,         32'h0001_0000},
            '{4'h8, 4'b0000, 32'h0,         32'h0},
            '{4'hC, 4'b0000, 32'h0,         32'h7},
            '{4'hC, 4'b0010, 32'h5500,      32'h7},
            '{4'hC, 4'b0001, 32'hAB,        32'hAB},
            '{4'h0, 4'b0010, 32'h0501,      32'h0500},
            '{4'h0, 4'b0011, 32'h0002,      32'h0},
            '{4'h4, 4'b1111, 32'hFFFF_FFFF, 32'h0001_0000},
            '{4'h8, 4'b1111, 32'h1234_5678, 32'h0},
            '{4'hC, 4'b1111, 32'hFFFF_FF01, 32'h1}
        };
        repeat (3) @(posedge ck);
        #1;
        resetn = 1;
        @(posedge ck);
        #1;
        chk("rst_ready", 32'(iomem_ready), 0);
        chk("rst_rdata", iomem_rdata, 0);
        chk("rst_sck", 32'(i2s_sck), 0);
        chk("rst_ws", 32'(i2s_ws), 0);
        chk("rst_irq", 32'(irq), 0);
        foreach (vecs[i]) begin
            if (vecs[i].strb != 0) wr(vecs[i].off, vecs[i].strb, vecs[i].wd);
            rdchk($sformatf("reg_vec%0d", i), vecs[i].off, vecs[i].exp);
        end
        chk("ack_latency", 32'(lat), 0);
        chk("irq_idle", 32'(irq), 0);

        for (int c = 0; c < CH; c++) begin
            smp[0][c] = c == 0 ? 16'h8001 : W'($urandom);
            smp[1][c] = c == 0 ? 16'h1234 : W'($urandom);
        end
        start(32'h1, 0);
        t0 = -1;
        t1 = -1;
        p = i2s_sck;
        for (int n = 0; n < 40; n++) begin
            @(posedge ck);
            #1;
            if (!p && i2s_sck) begin
                if (t0 < 0) t0 = n;
                else if (t1 < 0) t1 = n;
            end
            p = i2s_sck;
        end
        chk("sck_period", 32'(t1 - t0), 4);
        wait_tot(60);
        stop(32'h0);
        chk("off_sck", 32'(i2s_sck), 0);
        chk("off_ws", 32'(i2s_ws), 0);
        rdchk("frame_status", 4'h4, status_m());
        for (int i = 0; i < 2 * CH; i++) begin
            popchk($sformatf("frame_pop%0d", i), x);
            if (i == 0) chk("frame_left_lit", x, 32'h0FFF_8001);
            if (i == CH) chk("frame_right_lit", x, 32'h8000_1234);
        end

        for (int c = 0; c < CH; c++) begin
            smp[0][c] = W'(c + 1);
            smp[1][c] = W'($urandom);
        end
        start(32'h0301, 0);
        wait_tot(20);
        stop(32'h0300);
        rdchk("order_status", 4'h4, status_m());
        chk("th_irq_fill4", 32'(irq), 32'(irq_m()));
        for (int i = 0; i < CH; i++) begin
            popchk($sformatf("order_pop%0d", i), x);
            chk($sformatf("order_lit%0d", i), x, (32'(i) << 28) | 32'(i + 1));
            chk($sformatf("th_irq_after_pop%0d", i), 32'(irq), 32'(irq_m()));
        end
        rdchk("order_empty", 4'h4, status_m());

        start(32'h1, 1);
        wait_tot(10);
        chk("ws_left", 32'(i2s_ws), 32'(k / 32));
        stop(32'h0);
        chk("dis_sck", 32'(i2s_sck), 0);
        chk("dis_ws", 32'(i2s_ws), 0);
        rdchk("dis_no_push", 4'h4, status_m());
        start(32'h1, 1);
        wait_tot(40);
        chk("ws_right", 32'(i2s_ws), 32'(k / 32));
        wait_tot(60);
        stop(32'h0);
        for (int i = 0; i < 2 * CH; i++) popchk($sformatf("reen_pop%0d", i), x);

        start(32'h1, 1);
        wait_tot(148);
        stop(32'h0);
        rdchk("ovf_status", 4'h4, status_m());
        chk("ovf_irq", 32'(irq), 32'(irq_m()));
        wr(4'h4, 4'b0100, 32'h0004_0000);
        ovf_m = 0;
        rdchk("ovf_clr_status", 4'h4, status_m());
        chk("ovf_clr_irq", 32'(irq), 32'(irq_m()));
        ctrl(32'h1000);
        chk("th16_irq", 32'(irq), 32'(irq_m()));
        ctrl(32'h1100);
        chk("th17_irq", 32'(irq), 32'(irq_m()));
        for (int i = 0; i < DEPTH - 2; i++) popchk($sformatf("ovf_pop%0d", i), x);
        ctrl(32'h0200);
        chk("th2_irq", 32'(irq), 32'(irq_m()));

        start(32'h0201, 1);
        wait_tot(148);
        stop(32'h0200);
        rdchk("ovf2_status", 4'h4, status_m());
        ctrl(32'h0202);
        rdchk("flush_status", 4'h4, status_m());
        chk("flush_irq", 32'(irq), 32'(irq_m()));
        popchk("flush_pop", x);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
